dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
// - Shares the single data-memory port between the load pipe and the store data queue (SDQ) drain.
// - Sequences SDQ issue:
//   - pulses sdq_issue_en_o;
//   - captures the entry the SDQ registers out one cycle later;
//   - writes that entry to memory.
// - One memory transaction outstanding at a time. Loads win by default; committed stores get a bounded-starvation guarantee.
// PARAMETERS
// - ST_STARVE_LIMIT  4   consecutive load grants while a store is ready before the store is forced ahead (>=1)
// - CNT_W            32  width of the perf counters (used only with DMEM_ARB_PERF_EN)
// PORTS
// - clk_i               in   1   clock
// - rst_ni              in   1   asynchronous reset, active low
// - flush_i             in   1   pipeline flush; squashes uncommitted load traffic
// - ld_req_vld_i        in   1   load request valid
// - ld_req_addr_i       in   32  load address
// - ld_req_rdy_o        out  1   load accepted this cycle (vld & rdy)
// - ld_resp_vld_o       out  1   load data valid
// - ld_resp_data_o      out  32  load data
// - sdq_head_rdy_i      in   1   SDQ head is valid, addr_valid and committed
// - sdq_issue_en_o      out  1   one-cycle pulse requesting an SDQ issue
// - sdq_issue_vld_i     in   1   SDQ issued entry valid (one cycle after issue_en)
// - sdq_issue_addr_i    in   32  issued store address
// - sdq_issue_data_i    in   32  issued store data
// - mem_req_vld_o       out  1   memory request valid
// - mem_req_we_o        out  1   1 = store, 0 = load
// - mem_req_addr_o      out  32  request address
// - mem_req_wdata_o     out  32  store data (0 for loads)
// - mem_req_rdy_i       in   1   memory accepts request
// - mem_resp_vld_i      in   1   response/ack for the outstanding request
// - mem_resp_data_i     in   32  load return data
// - st_done_o           out  1   pulse: store write acknowledged
// - busy_o              out  1   state != IDLE
// BEHAVIOUR
// - Reset (async, rst_ni=0): state=IDLE, streak=0, squash=0, all outputs 0. Reset mid-transaction abandons it; no response is forwarded.
// - FSM states: IDLE, ST_FETCH, MEM_REQ, MEM_WAIT.
// - IDLE arbitration (combinational):
//   - store_win = sdq_head_rdy_i & (~ld_req_vld_i | streak==ST_STARVE_LIMIT).
//   - ld_req_rdy_o = IDLE & ld_req_vld_i & ~store_win & ~flush_i.
//   - Load grant: latch addr, we=0 -> MEM_REQ.
//   - store_win: sdq_issue_en_o=1 for exactly this cycle -> ST_FETCH.
// - ST_FETCH (one cycle):
//   - sdq_issue_vld_i=1: latch addr/data, we=1 -> MEM_REQ.
//   - Else -> IDLE (no retry penalty beyond this cycle).
// - MEM_REQ:
//   - mem_req_vld_o=1; addr/we/wdata held stable until mem_req_rdy_i.
//   - Handshake (vld & rdy) -> MEM_WAIT.
//   - Load request is first presented the cycle after ld_req_rdy_o.
// - MEM_WAIT: on mem_resp_vld_i -> IDLE.
//   - Load and ~squash: ld_resp_vld_o=1, ld_resp_data_o=mem_resp_data_i in the same cycle (combinational pass-through).
//   - Store: st_done_o=1 for one cycle.
//   - The next grant can happen in the following IDLE cycle.
// - Streak counter:
//   - Load grant with sdq_head_rdy_i=1: +1, saturates at ST_STARVE_LIMIT.
//   - Clears on any store grant, or any cycle sdq_head_rdy_i=0.
// - Flush:
//   - IDLE: no load granted that cycle.
//   - MEM_REQ with a load: drop the request -> IDLE; a request already presented may be withdrawn.
//   - MEM_WAIT with a load: set squash; the response is consumed and dropped; squash clears when leaving MEM_WAIT.
//   - Stores are committed and are never affected by flush.
// - Simultaneous flush and mem_resp_vld_i on a load in MEM_WAIT: the response is dropped.
// - mem_resp_vld_i outside MEM_WAIT is ignored.
// CONFIGURATION
// - DMEM_ARB_PERF_EN defined:
//   - adds outputs perf_ld_cnt_o, perf_st_cnt_o, perf_starve_cnt_o [CNT_W-1:0];
//   - they count load handshakes, store handshakes, and forced store grants (streak==limit);
//   - wrap on overflow; cleared by reset.
// - DMEM_ARB_PERF_EN undefined: the ports and counters do not exist; behaviour is otherwise identical.
// TESTING
// - Load only: ld addr=0x100, mem rdy=1, resp 2 cycles later data=0xDEADBEEF.
//   -> ld_req_rdy_o at T, mem_req_vld_o at T+1, ld_resp 0xDEADBEEF, st_done_o never.
// - Store only: head_rdy=1, SDQ returns addr=0x40 data=0x12345678 at T+1.
//   -> mem_req_we_o=1 with those values at T+2, st_done_o on ack.
// - Starvation, limit=4: continuous loads with head_rdy=1.
//   -> exactly 4 load grants, then a store grant, then streak resets.
// - Flush during load MEM_WAIT, resp data=0xAAAA_5555.
//   -> ld_resp_vld_o stays 0, FSM returns to IDLE, next load completes normally.
// - ST_FETCH with sdq_issue_vld_i=0 -> IDLE next cycle, no mem request, a pending load is then granted.
// - Reset asserted in MEM_REQ with mem_req_rdy_i=0 -> all outputs 0 immediately; a late mem_resp_vld_i is ignored.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: load pipe, SDQ issue and data-memory port signals shared by the arbiter and its environment; master = arbiter side, slave = environment side
interface dmem_port_arbiter_if;
    logic        ld_req_vld;
    logic [31:0] ld_req_addr;
    logic        ld_req_rdy;
    logic        ld_resp_vld;
    logic [31:0] ld_resp_data;
    logic        sdq_head_rdy;
    logic        sdq_issue_en;
    logic        sdq_issue_vld;
    logic [31:0] sdq_issue_addr;
    logic [31:0] sdq_issue_data;
    logic        mem_req_vld;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_req_rdy;
    logic        mem_resp_vld;
    logic [31:0] mem_resp_data;
    logic        st_done;
    logic        busy;
    modport master (
        input  ld_req_vld, ld_req_addr, sdq_head_rdy, sdq_issue_vld, sdq_issue_addr, sdq_issue_data,
               mem_req_rdy, mem_resp_vld, mem_resp_data,
        output ld_req_rdy, ld_resp_vld, ld_resp_data, sdq_issue_en, mem_req_vld, mem_req_we,
               mem_req_addr, mem_req_wdata, st_done, busy
    );
    modport slave (
        output ld_req_vld, ld_req_addr, sdq_head_rdy, sdq_issue_vld, sdq_issue_addr, sdq_issue_data,
               mem_req_rdy, mem_resp_vld, mem_resp_data,
        input  ld_req_rdy, ld_resp_vld, ld_resp_data, sdq_issue_en, mem_req_vld, mem_req_we,
               mem_req_addr, mem_req_wdata, st_done, busy
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between loads and SDQ store drain (clk_i, rst_ni async low, flush_i, bus = dmem_port_arbiter_if.master; DMEM_ARB_PERF_EN adds perf_ld_cnt_o/perf_st_cnt_o/perf_starve_cnt_o)
module dmem_port_arbiter #(
    parameter int ST_STARVE_LIMIT = 4
`ifdef DMEM_ARB_PERF_EN
    , parameter int CNT_W = 32
`endif
) (
    input logic clk_i,
    input logic rst_ni,
    input logic flush_i,
    dmem_port_arbiter_if.master bus
`ifdef DMEM_ARB_PERF_EN
    , output logic [CNT_W-1:0] perf_ld_cnt_o
    , output logic [CNT_W-1:0] perf_st_cnt_o
    , output logic [CNT_W-1:0] perf_starve_cnt_o
`endif
);
    localparam int SW = $clog2(ST_STARVE_LIMIT + 1);
    typedef enum logic [1:0] {IDLE, ST_FETCH, MEM_REQ, MEM_WAIT} state_t;
    state_t state, state_nxt;
    logic [SW-1:0] streak;
    logic squash, req_we;
    logic [31:0] req_addr, req_wdata;
    logic forced, store_win, idle, ld_grant, st_grant, mem_hs, resp;
    assign forced    = streak == SW'(ST_STARVE_LIMIT);
    assign store_win = bus.sdq_head_rdy & (~bus.ld_req_vld | forced);
    // reset gates the combinational grants so every output reads 0 while rst_ni is low
    assign idle      = (state == IDLE) & rst_ni;
    assign ld_grant  = idle & bus.ld_req_vld & ~store_win & ~flush_i;
    assign st_grant  = idle & store_win;
    assign mem_hs    = (state == MEM_REQ) & bus.mem_req_rdy;
    assign resp      = (state == MEM_WAIT) & bus.mem_resp_vld;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = ld_grant ? MEM_REQ : st_grant ? ST_FETCH : IDLE;
            ST_FETCH: state_nxt = bus.sdq_issue_vld ? MEM_REQ : IDLE;
            // an accepted request always waits for its response, even under flush, so a
            // stale response can never be credited to a later transaction
            MEM_REQ:  state_nxt = bus.mem_req_rdy ? MEM_WAIT : (flush_i & ~req_we) ? IDLE : MEM_REQ;
            MEM_WAIT: state_nxt = bus.mem_resp_vld ? IDLE : MEM_WAIT;
            default:  state_nxt = IDLE;
        endcase
        bus.ld_req_rdy    = ld_grant;
        bus.sdq_issue_en  = st_grant;
        bus.mem_req_vld   = state == MEM_REQ;
        bus.mem_req_we    = req_we;
        bus.mem_req_addr  = req_addr;
        bus.mem_req_wdata = req_wdata;
        bus.ld_resp_vld   = resp & ~req_we & ~squash & ~flush_i;
        bus.ld_resp_data  = bus.ld_resp_vld ? bus.mem_resp_data : 32'h0;
        bus.st_done       = resp & req_we;
        bus.busy          = state != IDLE;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            streak    <= '0;
            squash    <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else begin
            state  <= state_nxt;
            streak <= (~bus.sdq_head_rdy | st_grant) ? '0 : (ld_grant & ~forced) ? streak + 1'b1 : streak;
            squash <= (state == MEM_REQ)  ? (mem_hs & flush_i & ~req_we) :
                      (state == MEM_WAIT) ? (~bus.mem_resp_vld & (squash | (flush_i & ~req_we))) : 1'b0;
            if (ld_grant) begin
                req_we    <= 1'b0;
                req_addr  <= bus.ld_req_addr;
                req_wdata <= '0;
            end
            if (state == ST_FETCH && bus.sdq_issue_vld) begin
                req_we    <= 1'b1;
                req_addr  <= bus.sdq_issue_addr;
                req_wdata <= bus.sdq_issue_data;
            end
        end
    end
`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_ld_cnt_o     <= '0;
            perf_st_cnt_o     <= '0;
            perf_starve_cnt_o <= '0;
        end else begin
            if (mem_hs & ~req_we) perf_ld_cnt_o <= perf_ld_cnt_o + 1'b1;
            if (mem_hs & req_we) perf_st_cnt_o <= perf_st_cnt_o + 1'b1;
            if (st_grant & forced) perf_starve_cnt_o <= perf_starve_cnt_o + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and randomized checks of dmem_port_arbiter against a transaction-level model
module tb_dmem_port_arbiter;
    localparam int LIMIT = 4;
    localparam int P_IDLE = 0, P_FETCH = 1, P_REQ = 2, P_WAIT = 3;
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic flush = 1'b0;
    int tests = 0;
    int fails = 0;
    dmem_port_arbiter_if b();
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_ld, perf_st, perf_starve;
`endif
    dmem_port_arbiter #(.ST_STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .flush_i(flush),
        .bus(b)
`ifdef DMEM_ARB_PERF_EN
        , .perf_ld_cnt_o(perf_ld)
        , .perf_st_cnt_o(perf_st)
        , .perf_starve_cnt_o(perf_starve)
`endif
    );
    always #5 clk = ~clk;
    // model: the one outstanding operation (phase + its payload) and the load streak
    int m_ph, m_streak;
    bit m_we, m_sq, last_iss;
    logic [31:0] m_addr, m_wdata;
    logic o_ldr, o_iss, o_mvld, o_we, o_lrv, o_std, o_busy;
    logic [31:0] o_addr, o_wdata, o_lrd;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        m_ph = P_IDLE; m_streak = 0; m_we = 0; m_sq = 0; last_iss = 0;
        m_addr = 0; m_wdata = 0;
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_ld_req_rdy"}, b.ld_req_rdy, 0);
        chk({tag, "_ld_resp_vld"}, b.ld_resp_vld, 0);
        chk({tag, "_ld_resp_data"}, b.ld_resp_data, 0);
        chk({tag, "_issue_en"}, b.sdq_issue_en, 0);
        chk({tag, "_mem_req_vld"}, b.mem_req_vld, 0);
        chk({tag, "_mem_req_we"}, b.mem_req_we, 0);
        chk({tag, "_mem_req_addr"}, b.mem_req_addr, 0);
        chk({tag, "_mem_req_wdata"}, b.mem_req_wdata, 0);
        chk({tag, "_st_done"}, b.st_done, 0);
        chk({tag, "_busy"}, b.busy, 0);
    endtask
    // inputs are set by the caller just after a rising edge; check, clock, then advance the model
    task automatic step();
        bit sw, e_ldr, e_iss, e_lrv, e_std;
        #1;
        sw    = b.sdq_head_rdy && (!b.ld_req_vld || m_streak == LIMIT);
        e_iss = m_ph == P_IDLE && sw;
        e_ldr = m_ph == P_IDLE && b.ld_req_vld && !sw && !flush;
        e_lrv = m_ph == P_WAIT && !m_we && !m_sq && b.mem_resp_vld && !flush;
        e_std = m_ph == P_WAIT && m_we && b.mem_resp_vld;
        o_ldr = b.ld_req_rdy; o_iss = b.sdq_issue_en; o_mvld = b.mem_req_vld; o_we = b.mem_req_we;
        o_addr = b.mem_req_addr; o_wdata = b.mem_req_wdata; o_lrv = b.ld_resp_vld; o_lrd = b.ld_resp_data;
        o_std = b.st_done; o_busy = b.busy;
        chk("ld_req_rdy", o_ldr, e_ldr);
        chk("sdq_issue_en", o_iss, e_iss);
        chk("mem_req_vld", o_mvld, m_ph == P_REQ);
        chk("ld_resp_vld", o_lrv, e_lrv);
        chk("ld_resp_data", o_lrd, e_lrv ? b.mem_resp_data : 32'h0);
        chk("st_done", o_std, e_std);
        chk("busy", o_busy, m_ph != P_IDLE);
        if (m_ph == P_REQ) begin
            chk("mem_req_we", o_we, m_we);
            chk("mem_req_addr", o_addr, m_addr);
            chk("mem_req_wdata", o_wdata, m_wdata);
        end
        @(posedge clk);
        if (!b.sdq_head_rdy || e_iss) m_streak = 0;
        else if (e_ldr && m_streak < LIMIT) m_streak++;
        case (m_ph)
            P_IDLE: if (e_ldr) begin
                m_ph = P_REQ; m_we = 0; m_addr = b.ld_req_addr; m_wdata = 0;
            end else if (e_iss) m_ph = P_FETCH;
            P_FETCH: if (b.sdq_issue_vld) begin
                m_ph = P_REQ; m_we = 1; m_addr = b.sdq_issue_addr; m_wdata = b.sdq_issue_data;
            end else m_ph = P_IDLE;
            P_REQ: if (b.mem_req_rdy) begin
                m_ph = P_WAIT; m_sq = flush && !m_we;
            end else if (flush && !m_we) m_ph = P_IDLE;
            default: if (b.mem_resp_vld) begin
                m_ph = P_IDLE; m_sq = 0;
            end else if (flush && !m_we) m_sq = 1;
        endcase
        last_iss = e_iss;
        #1;
    endtask
    task automatic drive(input bit lv, input logic [31:0] la, input bit hr, input bit mr, input bit rv, input logic [31:0] rd);
        b.ld_req_vld = lv; b.ld_req_addr = la; b.sdq_head_rdy = hr;
        b.mem_req_rdy = mr; b.mem_resp_vld = rv; b.mem_resp_data = rd;
    endtask
    initial begin
        int grants, after;
        bit seen_st;
        drive(1, 32'h80, 1, 0, 1, 32'h55);
        b.sdq_issue_vld = 0; b.sdq_issue_addr = 0; b.sdq_issue_data = 0;
        model_reset();
        #12;
        chk_zero("reset");
        @(posedge clk); #1;
        rst_ni = 1;
        drive(0, 0, 0, 1, 0, 0);
        step();
        // load only
        drive(1, 32'h100, 0, 1, 0, 0); step();
        chk("load_grant_T", o_ldr, 1);
        drive(0, 0, 0, 1, 0, 0); step();
        chk("load_req_T1", o_mvld, 1);
        chk("load_req_addr", o_addr, 32'h100);
        step();
        drive(0, 0, 0, 1, 1, 32'hDEADBEEF); step();
        chk("load_resp_vld", o_lrv, 1);
        chk("load_resp_data", o_lrd, 32'hDEADBEEF);
        chk("load_no_st_done", o_std, 0);
        // store only
        drive(0, 0, 1, 1, 0, 0); step();
        chk("store_issue", o_iss, 1);
        drive(0, 0, 0, 1, 0, 0);
        b.sdq_issue_vld = 1; b.sdq_issue_addr = 32'h40; b.sdq_issue_data = 32'h12345678; step();
        b.sdq_issue_vld = 0; step();
        chk("store_req_we", o_we, 1);
        chk("store_req_addr", o_addr, 32'h40);
        chk("store_req_wdata", o_wdata, 32'h12345678);
        drive(0, 0, 0, 1, 1, 0); step();
        chk("store_done", o_std, 1);
        // starvation: continuous loads with a ready store
        grants = 0; after = 0; seen_st = 0;
        for (int i = 0; i < 40 && after == 0; i++) begin
            drive(1, 32'h1000 + i * 4, 1, 1, 1, i);
            b.sdq_issue_vld = last_iss; b.sdq_issue_addr = 32'h80; b.sdq_issue_data = 32'h77;
            step();
            if (o_iss) seen_st = 1;
            if (o_ldr && !seen_st) grants++;
            if (o_ldr && seen_st) after = 1;
        end
        chk("starve_load_grants", grants, LIMIT);
        chk("starve_store_granted", seen_st, 1);
        chk("starve_load_after_store", after, 1);
        b.sdq_issue_vld = 0;
        drive(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) step();
        // flush during load MEM_WAIT
        drive(1, 32'h200, 0, 1, 0, 0); step();
        drive(0, 0, 0, 1, 0, 0); step();
        flush = 1; step();
        flush = 0; drive(0, 0, 0, 1, 1, 32'hAAAA5555); step();
        chk("flush_resp_dropped", o_lrv, 0);
        drive(0, 0, 0, 1, 0, 0); step();
        chk("flush_back_idle", o_busy, 0);
        drive(1, 32'h204, 0, 1, 0, 0); step();
        drive(0, 0, 0, 1, 0, 0); step();
        drive(0, 0, 0, 1, 1, 32'h0BADF00D); step();
        chk("flush_next_load", o_lrv, 1);
        chk("flush_next_data", o_lrd, 32'h0BADF00D);
        // failed SDQ fetch
        drive(0, 0, 1, 1, 0, 0); step();
        drive(1, 32'h300, 0, 1, 0, 0); b.sdq_issue_vld = 0; step();
        chk("fetch_fail_no_req", o_mvld, 0);
        step();
        chk("fetch_fail_load_grant", o_ldr, 1);
        drive(0, 0, 0, 1, 0, 0); step();
        drive(0, 0, 0, 1, 1, 32'h1); step();
        // reset while MEM_REQ stalls
        drive(1, 32'h400, 0, 0, 0, 0); step();
        step();
        chk("rst_pre_req", o_mvld, 1);
        rst_ni = 0; b.sdq_head_rdy = 1;
        #1;
        chk_zero("rst_mid");
        b.mem_resp_vld = 1; b.mem_resp_data = 32'hFFFF0000;
        @(posedge clk); #1;
        rst_ni = 1; model_reset();
        drive(0, 0, 0, 0, 1, 32'hFFFF0000); step();
        chk("rst_late_resp", o_lrv, 0);
        drive(0, 0, 0, 0, 0, 0); step();
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(9) < 6, $urandom, $urandom_range(9) < 5, $urandom_range(1),
                  $urandom_range(2) == 0, $urandom);
            flush = $urandom_range(19) == 0;
            b.sdq_issue_vld = last_iss && $urandom_range(4) != 0;
            b.sdq_issue_addr = $urandom; b.sdq_issue_data = $urandom;
            step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
